// File: rtl/half_subtractor_if.sv
// Operand, control and result bundle for the half subtractor.
// The master drives operands and control; the slave (the subtractor) returns results.
interface half_subtractor_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             in_valid;
  logic             cnt_clr;
  logic [WIDTH-1:0] Diff;
  logic [WIDTH-1:0] Borrow;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] borrow_q;
  logic             out_valid;
  logic [CNT_W-1:0] borrow_cnt;

  modport master (
    output A, B, in_valid, cnt_clr,
    input  Diff, Borrow, diff_q, borrow_q, out_valid, borrow_cnt
  );

  modport slave (
    input  A, B, in_valid, cnt_clr,
    output Diff, Borrow, diff_q, borrow_q, out_valid, borrow_cnt
  );
endinterface

// File: rtl/half_subtractor.sv
// Bit-parallel half subtractor (A - B per lane) with a combinational result,
// a registered valid-qualified copy and a saturating borrow-event counter.
module half_subtractor #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  half_subtractor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_borrow;
  logic             w_any_borrow;
  logic             w_cnt_inc;

  logic [WIDTH-1:0] r_diff_q;
  logic [WIDTH-1:0] r_borrow_q;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_borrow_cnt;

  // Lanes are fully independent: no borrow ripples between them.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      assign w_diff[gi]   = bus.A[gi] ^ bus.B[gi];
      assign w_borrow[gi] = ~bus.A[gi] & bus.B[gi];
    end
  endgenerate

  assign w_any_borrow = |w_borrow;
  assign w_cnt_inc    = bus.in_valid && w_any_borrow && (r_borrow_cnt != CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff_q     <= '0;
      r_borrow_q   <= '0;
      r_out_valid  <= 1'b0;
      r_borrow_cnt <= '0;
    end else begin
      if (bus.in_valid) begin
        r_diff_q   <= w_diff;
        r_borrow_q <= w_borrow;
      end
      r_out_valid <= bus.in_valid;
      // Clear has priority over a same-cycle borrow event.
      if (bus.cnt_clr) begin
        r_borrow_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_borrow_cnt <= r_borrow_cnt + 1'b1;
      end
    end
  end

  assign bus.Diff       = w_diff;
  assign bus.Borrow     = w_borrow;
  assign bus.diff_q     = r_diff_q;
  assign bus.borrow_q   = r_borrow_q;
  assign bus.out_valid  = r_out_valid;
  assign bus.borrow_cnt = r_borrow_cnt;

endmodule

// File: tb/tb_half_subtractor.sv
// Randomized self-checking bench: a 4-lane/16-bit-counter instance and a
// 1-lane/2-bit-counter instance run against an arithmetic reference model.
module tb_half_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  half_subtractor_if #(.WIDTH(4), .CNT_W(16)) if4 ();
  half_subtractor_if #(.WIDTH(1), .CNT_W(2))  if1 ();

  half_subtractor #(.WIDTH(4), .CNT_W(16)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  half_subtractor #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  // Reference: each lane is the integer a - b; a nonzero result flips the
  // difference bit, a negative result is a borrow.
  function automatic logic [3:0] f_diff(input int w, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      int s;
      s = int'(a[i]) - int'(b[i]);
      r[i] = (s != 0);
    end
    return r;
  endfunction

  function automatic logic [3:0] f_borrow(input int w, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      int s;
      s = int'(a[i]) - int'(b[i]);
      r[i] = (s < 0);
    end
    return r;
  endfunction

  function automatic int f_cnt(input int cnt, input logic clr, input logic vld,
                               input logic [3:0] br, input int max);
    if (clr) return 0;
    if (vld && (br != 0) && (cnt < max)) return cnt + 1;
    return cnt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state.
  logic [3:0] m4_dq = '0, m4_bq = '0, m1_dq = '0, m1_bq = '0;
  logic       m4_v = 1'b0, m1_v = 1'b0;
  int         m4_cnt = 0, m1_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4_dq <= '0; m4_bq <= '0; m4_v <= 1'b0; m4_cnt <= 0;
      m1_dq <= '0; m1_bq <= '0; m1_v <= 1'b0; m1_cnt <= 0;
    end else begin
      if (if4.in_valid) begin
        m4_dq <= f_diff(4, if4.A, if4.B);
        m4_bq <= f_borrow(4, if4.A, if4.B);
      end
      m4_v   <= if4.in_valid;
      m4_cnt <= f_cnt(m4_cnt, if4.cnt_clr, if4.in_valid, f_borrow(4, if4.A, if4.B), 65535);
      if (if1.in_valid) begin
        m1_dq <= f_diff(1, 4'(if1.A), 4'(if1.B));
        m1_bq <= f_borrow(1, 4'(if1.A), 4'(if1.B));
      end
      m1_v   <= if1.in_valid;
      m1_cnt <= f_cnt(m1_cnt, if1.cnt_clr, if1.in_valid, f_borrow(1, 4'(if1.A), 4'(if1.B)), 3);
    end
  end

  // Compare every cycle, mid-way between active edges.
  always @(negedge clk) begin
    chk("w4_diff",     32'(if4.Diff),       32'(f_diff(4, if4.A, if4.B)));
    chk("w4_borrow",   32'(if4.Borrow),     32'(f_borrow(4, if4.A, if4.B)));
    chk("w4_diff_q",   32'(if4.diff_q),     32'(m4_dq));
    chk("w4_borrow_q", 32'(if4.borrow_q),   32'(m4_bq));
    chk("w4_valid",    32'(if4.out_valid),  32'(m4_v));
    chk("w4_cnt",      32'(if4.borrow_cnt), 32'(m4_cnt));
    chk("w1_diff",     32'(if1.Diff),       32'(f_diff(1, 4'(if1.A), 4'(if1.B))));
    chk("w1_borrow",   32'(if1.Borrow),     32'(f_borrow(1, 4'(if1.A), 4'(if1.B))));
    chk("w1_diff_q",   32'(if1.diff_q),     32'(m1_dq));
    chk("w1_borrow_q", 32'(if1.borrow_q),   32'(m1_bq));
    chk("w1_valid",    32'(if1.out_valid),  32'(m1_v));
    chk("w1_cnt",      32'(if1.borrow_cnt), 32'(m1_cnt));
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  logic [1:0] tt_in [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] tt_out [4] = '{2'b00, 2'b11, 2'b10, 2'b00};

  initial begin
    if4.A = '0; if4.B = '0; if4.in_valid = 1'b0; if4.cnt_clr = 1'b0;
    if1.A = '0; if1.B = '0; if1.in_valid = 1'b0; if1.cnt_clr = 1'b0;
    step(); step();
    chk("reset_valid", 32'(if4.out_valid), 32'd0);
    chk("reset_cnt",   32'(if4.borrow_cnt), 32'd0);
    rst_n = 1'b1;

    // WIDTH=1 truth table, each pattern held 10ns.
    for (int i = 0; i < 4; i++) begin
      if1.A = tt_in[i][1];
      if1.B = tt_in[i][0];
      #1;
      chk("truth_table", 32'({if1.Diff, if1.Borrow}), 32'(tt_out[i]));
      #9;
    end
    step();

    // Single borrow sample on the 1-lane instance, then an idle cycle.
    if1.A = 1'b0; if1.B = 1'b1; if1.in_valid = 1'b1;
    step();
    chk("first_diff_q",   32'(if1.diff_q),     32'd1);
    chk("first_borrow_q", 32'(if1.borrow_q),   32'd1);
    chk("first_valid",    32'(if1.out_valid),  32'd1);
    chk("first_cnt",      32'(if1.borrow_cnt), 32'd1);
    if1.A = 1'b1; if1.B = 1'b0; if1.in_valid = 1'b0;
    step();
    chk("idle_valid",  32'(if1.out_valid),  32'd0);
    chk("idle_diff_q", 32'(if1.diff_q),     32'd1);
    chk("idle_bq",     32'(if1.borrow_q),   32'd1);
    chk("idle_cnt",    32'(if1.borrow_cnt), 32'd1);

    // Saturation of the 2-bit counter, then clear beats a borrow sample.
    if1.cnt_clr = 1'b1;
    step();
    if1.cnt_clr = 1'b0; if1.A = 1'b0; if1.B = 1'b1; if1.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("sat_cnt", 32'(if1.borrow_cnt), 32'd3);
    if1.cnt_clr = 1'b1;
    step();
    chk("clr_wins", 32'(if1.borrow_cnt), 32'd0);
    if1.cnt_clr = 1'b0; if1.in_valid = 1'b0;

    // Lane independence on the 4-lane instance.
    if4.A = 4'b1100; if4.B = 4'b1010; if4.in_valid = 1'b1;
    #1;
    chk("lanes_diff",   32'(if4.Diff),   32'h6);
    chk("lanes_borrow", 32'(if4.Borrow), 32'h2);
    step();
    chk("lanes_diff_q",   32'(if4.diff_q),   32'h6);
    chk("lanes_borrow_q", 32'(if4.borrow_q), 32'h2);

    // Build borrow_cnt=5, then reset asynchronously mid-run.
    if4.cnt_clr = 1'b1; if4.in_valid = 1'b0;
    step();
    if4.cnt_clr = 1'b0; if4.A = 4'b0000; if4.B = 4'b0001; if4.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_cnt",   32'(if4.borrow_cnt), 32'd5);
    chk("pre_rst_valid", 32'(if4.out_valid),  32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(if4.out_valid),  32'd0);
    chk("async_rst_cnt",   32'(if4.borrow_cnt), 32'd0);
    chk("async_rst_dq",    32'(if4.diff_q),     32'd0);
    chk("async_rst_bq",    32'(if4.borrow_q),   32'd0);
    step();
    rst_n = 1'b1;

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      if4.A        = 4'($urandom_range(0, 15));
      if4.B        = 4'($urandom_range(0, 15));
      if4.in_valid = ($urandom_range(0, 9) < 7);
      if4.cnt_clr  = ($urandom_range(0, 19) == 0);
      if1.A        = 1'($urandom_range(0, 1));
      if1.B        = 1'($urandom_range(0, 1));
      if1.in_valid = ($urandom_range(0, 9) < 7);
      if1.cnt_clr  = ($urandom_range(0, 19) == 0);
      step();
    end
    if4.in_valid = 1'b0; if1.in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
